// File: rtl/cp_rd_dt_conv_p.sv
// Narrow-read to wide-buffer data width converter with a single-word hold cache.
// Hit path enabled by defining CP_RDDTCONV_CACHE_EN; otherwise every read fetches.
module cp_rd_dt_conv_p #(
    parameter int  WIDE_W   = 128,
    parameter int  NARROW_W = 32,
    parameter int  WADDR_W  = 7,
    parameter int  RAM_LAT  = 1,
    localparam int LANE_W   = $clog2(WIDE_W / NARROW_W)
) (
    input  logic                      iClk,
    input  logic                      iRsn,
    input  logic                      iRdReq,
    input  logic [WADDR_W+LANE_W-1:0] iRdAddr,
    output logic                      oRdBusy,
    output logic                      oRdVld,
    output logic [NARROW_W-1:0]       oRdDt,
    input  logic                      iCacheInv,
    output logic                      oRdEn_Buf,
    output logic [WADDR_W-1:0]        oRdAddr_Buf,
    input  logic [WIDE_W-1:0]         iRdDt_Buf
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_vld;
    logic [NARROW_W-1:0] r_dt;
    logic                r_en;
    logic [WADDR_W-1:0]  r_buf_addr;
    logic [WADDR_W-1:0]  r_waddr;
    logic [LANE_W-1:0]   r_lane;
    logic [WIDE_W-1:0]   r_hold;
    logic [WADDR_W-1:0]  r_hold_addr;
    logic                r_hold_vld;
    logic [1:0]          r_cnt;

    logic [WADDR_W-1:0]  w_waddr;
    logic [LANE_W-1:0]   w_lane;
    logic                w_accept;
    logic                w_hit;
    logic                w_fill_vld;

    function automatic logic [NARROW_W-1:0] f_lane(input logic [WIDE_W-1:0] w,
                                                   input logic [LANE_W-1:0] l);
        return w[int'(l)*NARROW_W +: NARROW_W];
    endfunction

    assign w_waddr  = iRdAddr[WADDR_W+LANE_W-1:LANE_W];
    assign w_lane   = iRdAddr[LANE_W-1:0];
    assign w_accept = iRdReq && ((r_state == S_IDLE) || (r_state == S_RESP));
    assign w_hit    = r_hold_vld && (r_hold_addr == w_waddr) && !iCacheInv;

`ifdef CP_RDDTCONV_CACHE_EN
    // Any invalidate between acceptance and capture makes the fetched word untrusted.
    logic r_inv_seen;
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn)
            r_inv_seen <= 1'b0;
        else if (w_accept)
            r_inv_seen <= 1'b0;
        else if (iCacheInv)
            r_inv_seen <= 1'b1;
    end
    assign w_fill_vld = ~(r_inv_seen | iCacheInv);
`else
    assign w_fill_vld = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_vld       <= 1'b0;
            r_dt        <= '0;
            r_en        <= 1'b0;
            r_buf_addr  <= '0;
            r_waddr     <= '0;
            r_lane      <= '0;
            r_hold      <= '0;
            r_hold_addr <= '0;
            r_hold_vld  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_vld      <= 1'b0;
            r_en       <= 1'b0;
            r_buf_addr <= '0;
            if (iCacheInv)
                r_hold_vld <= 1'b0;
            unique case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_waddr <= w_waddr;
                        r_lane  <= w_lane;
                        if (w_hit) begin
                            r_vld   <= 1'b1;
                            r_dt    <= f_lane(r_hold, w_lane);
                            r_state <= S_RESP;
                        end else begin
                            r_en       <= 1'b1;
                            r_buf_addr <= w_waddr;
                            r_busy     <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    r_cnt   <= 2'(RAM_LAT - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_hold      <= iRdDt_Buf;
                        r_hold_addr <= r_waddr;
                        r_hold_vld  <= w_fill_vld;
                        r_dt        <= f_lane(iRdDt_Buf, r_lane);
                        r_vld       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oRdBusy     = r_busy;
    assign oRdVld      = r_vld;
    assign oRdDt       = r_dt;
    assign oRdEn_Buf   = r_en;
    assign oRdAddr_Buf = r_buf_addr;

endmodule

// File: doc/cp_rd_dt_conv_p.md
Name: cp_rd_dt_conv_p

Overview:
Parametrised read-data width converter between a narrow host read port and a wide cipher output buffer. Generalises the fixed 128-to-32 combinational converter: width and ratio are parameters, the buffer read is registered with configurable latency, and responses use a request/valid handshake. Narrow reads that hit the most recently fetched wide word are served without a buffer access. Sits between the host bus read path and the AES output buffer.

Parameters:
WIDE_W, 128, buffer word width; must equal NARROW_W * 2^k with k >= 1.
NARROW_W, 32, host read data width.
WADDR_W, 7, wide buffer address width.
RAM_LAT, 1, buffer read latency in cycles, range 1..4.
LANE_W, derived, log2(WIDE_W/NARROW_W). Narrow address width is WADDR_W+LANE_W.

Ports:
iClk  in  1  clock
iRsn  in  1  asynchronous active-low reset
iRdReq  in  1  narrow read request; accepted when iRdReq=1 and oRdBusy=0
iRdAddr  in  WADDR_W+LANE_W  narrow word address
oRdBusy  out  1  converter cannot accept a request this cycle
oRdVld  out  1  one-cycle pulse; oRdDt is valid
oRdDt  out  NARROW_W  read data
iCacheInv  in  1  invalidate the held wide word; pulsed when the buffer is rewritten
oRdEn_Buf  out  1  buffer read enable, one-cycle pulse
oRdAddr_Buf  out  WADDR_W  buffer address; 0 when oRdEn_Buf=0
iRdDt_Buf  in  WIDE_W  buffer read data, valid RAM_LAT cycles after oRdEn_Buf

Behaviour:
- Clock and reset: single clock iClk; iRsn is asynchronous, active-low.
- Reset values: oRdBusy=0, oRdVld=0, oRdDt=0, oRdEn_Buf=0, oRdAddr_Buf=0; hold register=0, hold valid=0, held address=0; FSM in IDLE. Reset mid-operation aborts any pending fetch and issues no response.
- Address split: wide address = iRdAddr[WADDR_W+LANE_W-1:LANE_W]; lane = iRdAddr[LANE_W-1:0]. Lane n selects bits [(n+1)*NARROW_W-1 : n*NARROW_W], so lane 0 is the LSBs.
- Request capture: address is registered on acceptance. A hit means hold valid=1, held address equals the wide address, and iCacheInv=0 in the same cycle. If iCacheInv and a request coincide, the invalidate wins and the request is a miss.
- FSM states:
  - IDLE: oRdBusy=0. Hit: go to RESP. Miss: go to FETCH.
  - FETCH: oRdBusy=1, oRdEn_Buf=1, oRdAddr_Buf=registered wide address. Go to WAIT; the latency counter loads RAM_LAT-1.
  - WAIT: oRdBusy=1. When the counter reaches 0, capture iRdDt_Buf into the hold register and go to RESP. Hold valid is set unless iCacheInv was seen at any point since FETCH.
  - RESP: oRdVld=1 and oRdDt=selected lane (registered). oRdBusy=0, so a new request may be accepted in this cycle with the same hit/miss rule, giving back-to-back operation. With no request, go to IDLE.
- Latency, request accepted in cycle T:
  - Hit: oRdVld in cycle T+1.
  - Miss: oRdEn_Buf in T+1, oRdVld in T+2+RAM_LAT.
- Data hold: oRdDt keeps its last value while oRdVld=0.
- iCacheInv in any state clears hold valid at the next edge. It never cancels an in-flight response, which still returns the fetched data.
- iRdReq while oRdBusy=1 is ignored; the requester must hold it.

Optional Feature:
Macro CP_RDDTCONV_CACHE_EN.
- Defined: hit path as described above.
- Undefined: hold valid is tied to 0, every request is a miss and takes the FETCH/WAIT path, and iCacheInv is ignored. Port list is unchanged.

Test Plan:
- Reset, then read iRdAddr=0x005 (wide 1, lane 1) with buffer word 1 = 0x33333333_22222222_11111111_00000000 -> oRdEn_Buf pulse at T+1 with address 1; oRdVld at T+3 (RAM_LAT=1) with oRdDt=0x11111111.
- Back-to-back reads 0x004, 0x006, 0x007 after the first fetch, cache enabled -> no further oRdEn_Buf; oRdDt 0x00000000, 0x22222222, 0x33333333, each 1 cycle after acceptance.
- Read 0x005, pulse iCacheInv, read 0x005 again -> second read refetches (oRdEn_Buf asserted, address 1).
- iCacheInv in the same cycle as a hitting request -> treated as a miss, fetch issued.
- RAM_LAT=3, miss at address 0x1FF -> oRdAddr_Buf=0x7F, oRdVld at T+5 with lane 3 data. Assert iRsn low during WAIT -> no oRdVld; all outputs 0.
- Macro undefined: repeat the reads of scenario 2 -> oRdEn_Buf issued on every read.
